// File: rtl/nvram_backup_pkg.sv
// Shared types and constants for the save-RAM backup sequencer.
package nvram_backup_pkg;

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

  localparam int SECTOR_BYTES = 512;

  function automatic int buf_aw(input int sectors);
    return $clog2(sectors * SECTOR_BYTES);
  endfunction

endpackage

// File: rtl/nvram_backup_if.sv
// SD-image sector handshake between user_io and the backup sequencer,
// plus the NVRAM port-B address/write derived from it.
interface nvram_backup_if #(
  parameter int BUF_AW = 13
);
  logic [31:0]       sd_lba;
  logic              sd_rd;
  logic              sd_wr;
  logic              sd_ack;
  logic [8:0]        sd_buff_addr;
  logic              sd_buff_wr;
  logic [BUF_AW-1:0] buf_addr;
  logic              buf_we;

  modport master (
    output sd_lba, sd_rd, sd_wr, buf_addr, buf_we,
    input  sd_ack, sd_buff_addr, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, buf_addr, buf_we,
    output sd_ack, sd_buff_addr, sd_buff_wr
  );
endinterface

// File: rtl/nvram_backup_edge_det.sv
// Registered edge detector: rise/fall compare the live input with its value
// from the previous clock.
module edge_det (
  input  logic clk_sys,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic old_reg;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) old_reg <= 1'b0;
    else       old_reg <= d;
  end

  assign rise = d & ~old_reg;
  assign fall = ~d & old_reg;
endmodule

// File: rtl/nvram_backup.sv
// Save-RAM backup sequencer: loads the mounted image into NVRAM port B,
// writes it back on save request, and tracks NVRAM dirtiness.
module nvram_backup
  import nvram_backup_pkg::*;
#(
  parameter int SECTORS = 16,
  parameter int SEC_W   = 4,
  parameter int BUF_AW  = buf_aw(SECTORS)
) (
  input  logic           clk_sys,
  input  logic           reset,
  input  logic           img_mounted,
  input  logic [31:0]    img_size,
  input  logic           ioctl_download,
  input  logic           save_req,
  input  logic           nvram_we,
  nvram_backup_if.master sd,
  output logic           bk_ena,
  output logic           bk_busy,
  output logic           bk_reset,
  output logic           dirty
);
  localparam int ED_N     = 4;
  localparam int ED_MOUNT = 0;
  localparam int ED_SAVE  = 1;
  localparam int ED_ACK   = 2;
  localparam int ED_DL    = 3;
  localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(SECTORS - 1);

  logic [ED_N-1:0] ed_in, ed_rise, ed_fall;
  logic            unused_fall;

  assign ed_in = {ioctl_download, sd.sd_ack, save_req, img_mounted};

  generate
    for (genvar gi = 0; gi < ED_N; gi++) begin : g_ed
      edge_det u_edge_det (
        .clk_sys (clk_sys),
        .reset   (reset),
        .d       (ed_in[gi]),
        .rise    (ed_rise[gi]),
        .fall    (ed_fall[gi])
      );
    end
  endgenerate

  assign unused_fall = ^{ed_fall[ED_DL], ed_fall[ED_SAVE], ed_fall[ED_MOUNT]};

  state_t           state_reg, state_next;
  logic [SEC_W-1:0] lba_reg;
  logic             sd_rd_reg, sd_wr_reg;
  logic             loading_reg, load_pend_reg, abort_reg;
  logic             bk_ena_reg, bk_reset_reg, dirty_reg;

  logic start_load, start_save, req_acked, sec_next, xfer_end;

  always_comb begin
    state_next = state_reg;
    start_load = 1'b0;
    start_save = 1'b0;
    req_acked  = 1'b0;
    sec_next   = 1'b0;
    xfer_end   = 1'b0;
    case (state_reg)
      IDLE: begin
        // A mount edge arriving with a save edge wins: the load it queues
        // starts next cycle and the save edge is dropped.
        if (bk_ena_reg && load_pend_reg) begin
          start_load = 1'b1;
          state_next = REQ;
        end else if (bk_ena_reg && ed_rise[ED_SAVE] && !ed_rise[ED_MOUNT]) begin
          start_save = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (ed_rise[ED_ACK]) begin
          req_acked  = 1'b1;
          state_next = XFER;
        end
      end
      XFER: begin
        if (ed_fall[ED_ACK]) begin
          if (lba_reg == LAST_SEC || abort_reg) begin
            state_next = DONE;
          end else begin
            sec_next   = 1'b1;
            state_next = REQ;
          end
        end
      end
      DONE: begin
        xfer_end   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      lba_reg       <= '0;
      sd_rd_reg     <= 1'b0;
      sd_wr_reg     <= 1'b0;
      loading_reg   <= 1'b0;
      load_pend_reg <= 1'b0;
      abort_reg     <= 1'b0;
      bk_ena_reg    <= 1'b0;
      bk_reset_reg  <= 1'b0;
      dirty_reg     <= 1'b0;
    end else begin
      bk_reset_reg <= 1'b0;
      // A download seen while idle must not truncate the next transfer.
      if (state_reg == IDLE) abort_reg <= 1'b0;

      if (start_load) begin
        lba_reg       <= '0;
        loading_reg   <= 1'b1;
        sd_rd_reg     <= 1'b1;
        load_pend_reg <= 1'b0;
      end
      if (start_save) begin
        lba_reg     <= '0;
        loading_reg <= 1'b0;
        sd_wr_reg   <= 1'b1;
        dirty_reg   <= 1'b0;
      end
      if (req_acked) begin
        sd_rd_reg <= 1'b0;
        sd_wr_reg <= 1'b0;
      end
      if (sec_next) begin
        lba_reg   <= lba_reg + 1'b1;
        sd_rd_reg <= loading_reg;
        sd_wr_reg <= ~loading_reg;
      end
      if (xfer_end) begin
        bk_reset_reg <= loading_reg & ~abort_reg;
        if (loading_reg && !abort_reg) dirty_reg <= 1'b0;
        abort_reg    <= 1'b0;
        loading_reg  <= 1'b0;
      end

      if (ed_rise[ED_MOUNT]) begin
        bk_ena_reg    <= (img_size != 32'd0);
        load_pend_reg <= (img_size != 32'd0);
      end
      if (ed_rise[ED_DL]) begin
        bk_ena_reg    <= 1'b0;
        load_pend_reg <= 1'b0;
        dirty_reg     <= 1'b0;
        abort_reg     <= 1'b1;
      end
      if (nvram_we) dirty_reg <= 1'b1;
    end
  end

  assign sd.sd_lba   = {{(32 - SEC_W){1'b0}}, lba_reg};
  assign sd.sd_rd    = sd_rd_reg;
  assign sd.sd_wr    = sd_wr_reg;
  assign sd.buf_addr = {lba_reg, sd.sd_buff_addr};
  assign sd.buf_we   = sd.sd_buff_wr & sd.sd_ack & loading_reg;

  assign bk_ena   = bk_ena_reg;
  assign bk_busy  = (state_reg != IDLE);
  assign bk_reset = bk_reset_reg;
  assign dirty    = dirty_reg;
endmodule
